// File: rtl/shift_sequencer.sv
// shift_sequencer
// Command-driven controller for a 4-bit negedge multi-function shift register.
// Each accepted command applies one register opcode for N falling edges.
// The register is then parked in hold, and its final value is reported with a done pulse.
// The register has no native hold code.
// Hold is therefore built from the load opcode with D looped back from Q.

module shift_sequencer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [3:0]       cmd_data,
   input  logic [3:0]       cmd_sdata,
   input  logic [3:0]       q_in,
   output logic [2:0]       sel,
   output logic [3:0]       d_out,
   output logic             inp,
   output logic             busy,
   output logic             done,
   output logic [3:0]       result
);

   localparam logic [2:0]       OP_LOAD = 3'b001;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] rem;
   logic [1:0]       idx;
   logic [2:0]       op_q;
   logic [3:0]       data_q;
   logic [3:0]       sdata_q;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);

   // D follows Q so that the load opcode acts as hold, except while a real load command runs
   always_comb begin
      d_out = q_in;
      if (state == RUN && op_q == OP_LOAD) begin
         d_out = data_q;
      end
   end

   // Command acceptance, per-edge sequencing of opcode and serial bit, and completion reporting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= OP_LOAD;
         inp     <= 1'b0;
         done    <= 1'b0;
         result  <= 4'b0000;
         rem     <= CNT_ZERO;
         idx     <= 2'd0;
         op_q    <= 3'b000;
         data_q  <= 4'b0000;
         sdata_q <= 4'b0000;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               sel <= OP_LOAD;
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  data_q  <= cmd_data;
                  sdata_q <= cmd_sdata;
                  if (cmd_cnt != CNT_ZERO) begin
                     sel   <= cmd_op;
                     inp   <= cmd_sdata[0];
                     rem   <= cmd_cnt;
                     idx   <= 2'd1;
                     state <= RUN;
                  end else begin
                     done   <= 1'b1;
                     result <= q_in;
                  end
               end
            end
            RUN: begin
               if (rem == CNT_ONE) begin
                  sel    <= OP_LOAD;
                  inp    <= 1'b0;
                  done   <= 1'b1;
                  result <= q_in;
                  state  <= IDLE;
               end else begin
                  rem <= rem - CNT_ONE;
                  inp <= sdata_q[idx];
                  idx <= idx + 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
// Drives commands into shift_sequencer alongside a behavioural model of the negedge shift register.
// Expected completion results are queued at acceptance and compared when done pulses.

module tb_shift_sequencer;

   localparam int CNT_W = 3;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             cmd_valid = 1'b0;
   logic [2:0]       cmd_op    = 3'b000;
   logic [CNT_W-1:0] cmd_cnt   = '0;
   logic [3:0]       cmd_data  = 4'b0000;
   logic [3:0]       cmd_sdata = 4'b0000;
   logic [3:0]       q         = 4'b0110;
   logic             cmd_ready;
   logic [2:0]       sel;
   logic [3:0]       d_out;
   logic             inp;
   logic             busy;
   logic             done;
   logic [3:0]       result;

   typedef struct {
      logic [3:0] res;
      int         doneCycle;
      int         n;
   } exp_t;

   exp_t       sb[$];
   int         cycle      = 0;
   int         busyCycles = 0;
   int         passCount  = 0;
   int         checkCount = 0;
   int         lastAccept = 0;
   logic [3:0] refQ       = 4'b0110;

   shift_sequencer #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .cmd_data  (cmd_data),
      .cmd_sdata (cmd_sdata),
      .q_in      (q),
      .sel       (sel),
      .d_out     (d_out),
      .inp       (inp),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   // Behaviour of the external register for one falling edge
   function automatic logic [3:0] nextQ(input logic [2:0] op, input logic [3:0] cur,
                                        input logic [3:0] d, input logic s);
      case (op)
         3'b000:  return 4'b0000;
         3'b001:  return d;
         3'b010:  return {1'b0, cur[3:1]};
         3'b011:  return {cur[2:0], 1'b0};
         3'b100:  return {cur[3], cur[3:1]};
         3'b101:  return {s, cur[3:1]};
         3'b110:  return {cur[0], cur[3:1]};
         default: return {cur[2:0], cur[3]};
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end else begin
         passCount++;
      end
   endtask

   always #5 clk = ~clk;

   // Cycle counter used to time acceptance and completion
   always @(posedge clk) cycle <= cycle + 1;

   // The shift register itself, updating on the falling edge
   always @(negedge clk) begin
      if (!$isunknown(sel)) q <= nextQ(sel, q, d_out, inp);
   end

   // Completion monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      if (busy) busyCycles++;
      if (done) begin
         if (sb.size() == 0) begin
            checkOutput("spuriousDone", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("doneCycle", cycle, e.doneCycle);
            checkOutput("busyLen", busyCycles, e.n);
         end
         busyCycles = 0;
      end
   end

   // Offer a command until accepted; when completion is expected, queue its result
   task automatic applyStimulus(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                                input logic [3:0] data, input logic [3:0] sdata, input bit expectDone);
      logic rdy;
      bit   accepted;
      exp_t e;
      accepted = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_data  = data;
      cmd_sdata = sdata;
      for (int k = 0; k < 40; k++) begin
         rdy = cmd_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            accepted = 1'b1;
            break;
         end
      end
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_cnt   = CNT_W'($urandom);
      cmd_data  = 4'($urandom);
      cmd_sdata = 4'($urandom);
      if (!accepted) begin
         checkOutput("acceptTimeout", 0, 1);
      end else begin
         lastAccept = cycle;
         if (expectDone) begin
            for (int i = 0; i < int'(cnt); i++) refQ = nextQ(op, refQ, data, sdata[i % 4]);
            e.res       = refQ;
            e.doneCycle = cycle + int'(cnt);
            e.n         = int'(cnt);
            sb.push_back(e);
         end
      end
   endtask

   task automatic waitDone();
      for (int k = 0; k < 20; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #2;
      end
      checkOutput("doneTimeout", sb.size(), 0);
      sb.delete();
   endtask

   // One command with per-edge Q checking, then a check that Q holds afterwards
   task automatic runCommand(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                             input logic [3:0] data, input logic [3:0] sdata);
      logic [3:0] stepQ;
      stepQ = refQ;
      applyStimulus(op, cnt, data, sdata, 1'b1);
      for (int i = 0; i < int'(cnt); i++) begin
         @(negedge clk);
         #1;
         stepQ = nextQ(op, stepQ, data, sdata[i % 4]);
         checkOutput("qStep", q, stepQ);
      end
      waitDone();
      checkOutput("selHold", sel, 3'b001);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         checkOutput("qHold", q, refQ);
      end
   endtask

   task automatic checkIdleReset();
      checkOutput("rstSel", sel, 3'b001);
      checkOutput("rstDone", done, 0);
      checkOutput("rstResult", result, 4'b0000);
      checkOutput("rstReady", cmd_ready, 1);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstInp", inp, 0);
   endtask

   initial begin
      int         acceptA;
      logic [3:0] partial;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkIdleReset();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         checkOutput("rstQHeld", q, 4'b0110);
      end
      checkIdleReset();
      rst_n = 1'b1;

      runCommand(3'b001, 3'd1, 4'b1010, 4'b0000);
      runCommand(3'b111, 3'd3, 4'b0000, 4'b0000);

      runCommand(3'b000, 3'd2, 4'b0000, 4'b0000);
      runCommand(3'b101, 3'd4, 4'b0000, 4'b1101);

      runCommand(3'b001, 3'd3, 4'b1000, 4'b0000);
      applyStimulus(3'b100, 3'd2, 4'b0000, 4'b0000, 1'b1);
      acceptA = lastAccept;
      applyStimulus(3'b110, 3'd3, 4'b0000, 4'b0000, 1'b1);
      checkOutput("b2bAccept", lastAccept, acceptA + 3);
      waitDone();
      @(negedge clk);
      #1;
      checkOutput("b2bQ", q, refQ);

      runCommand(3'b101, 3'd7, 4'b0000, 4'b1011);

      runCommand(3'b001, 3'd1, 4'b0110, 4'b0000);
      runCommand(3'b000, 3'd0, 4'b0000, 4'b0000);

      partial = nextQ(3'b011, nextQ(3'b011, refQ, 4'b0000, 1'b0), 4'b0000, 1'b0);
      applyStimulus(3'b011, 3'd5, 4'b0000, 4'b0000, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abortSel", sel, 3'b001);
      checkOutput("abortBusy", busy, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         checkOutput("abortQ", q, partial);
         checkOutput("abortDone", done, 0);
      end
      rst_n = 1'b1;
      busyCycles = 0;
      refQ = partial;

      runCommand(3'b010, 3'd2, 4'b0000, 4'b0000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passCount, checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller for the 4-bit negedge multi-function shift register: the register's sel[2:0], D[3:0] and inp are driven from here, and its Q is fed back in.
- Accepts one command per valid/ready handshake (opcode, repeat count, load data, serial bits).
- Applies the opcode for exactly N falling edges, then parks the register in hold, pulses done and reports the final value.
- Hold is synthesised as sel=001 with D fed back from Q, because the register has no native hold code.

Parameters:
CNT_W, 3, width of repeat count; max applications per command = 2^CNT_W-1

Ports:
clk  in  1  system clock; controller acts on posedge, register samples on negedge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept; combinational, = (state==IDLE)
cmd_op  in  3  register opcode 000..111 (clear, load, lsr, lsl, asr, serial-in, ror, rol)
cmd_cnt  in  CNT_W  number of applications N
cmd_data  in  4  load value used when cmd_op=001
cmd_sdata  in  4  serial bits for op 101; application i drives bit i mod 4
q_in  in  4  register Q feedback
sel  out  3  register opcode, registered
d_out  out  4  register D, combinational
inp  out  1  register serial input, registered
busy  out  1  = (state==RUN)
done  out  1  one-cycle completion pulse, registered
result  out  4  q_in captured at completion, held until next completion

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=001, inp=0, done=0, result=0000, remaining count=0, latched op/data/sdata=0.
  - The register holds its contents during and after reset.
- States: IDLE, RUN.
- d_out:
  - = latched cmd_data when state==RUN and latched op==001.
  - = q_in otherwise, including hold. Settles within the half cycle before the negedge.
- IDLE:
  - sel=001 (hold).
  - Accept at posedge when cmd_valid & cmd_ready: latch op, data, sdata.
  - If N>=1: sel<=op, inp<=sdata[0], rem<=N, idx<=1, state<=RUN.
  - If N==0: stay IDLE, done<=1, result<=q_in; register untouched.
- RUN, each posedge:
  - If rem==1: sel<=001, inp<=0, done<=1, result<=q_in, state<=IDLE.
  - Else: rem<=rem-1, inp<=sdata[idx[1:0]], idx<=idx+1.
- Timing:
  - Accept at posedge t0 gives exactly N register updates, at the negedges between t0 and t0+N.
  - done is high for the cycle following posedge t0+N; result is valid in that same cycle.
- done is cleared on every posedge where it is not set.
- Back-to-back: cmd_ready is 1 during the done cycle, so a new command may be accepted at posedge t0+N+1.
- cmd_valid while busy: ignored, no latching. Command inputs need only be stable at the accept edge.
- Ops 000/001 with N>1: applied N times (idempotent); no special case.
- N=2^CNT_W-1 with op 101: serial bits wrap modulo 4.
- Reset mid-RUN: immediate abort to IDLE/hold; register keeps its partial value; no done.

Test Plan:
1. Reset asserted mid-idle -> sel=001, done=0, result=0000, cmd_ready=1; register Q unchanged across 5 clocks.
2. op=001, data=1010, N=1 -> Q=1010 after first negedge; done one cycle later, result=1010; busy high exactly 1 cycle.
3. From Q=1010, op=111 (rol), N=3 -> Q sequence 0101,1010,0101; result=0101; done exactly 3 cycles after accept; Q held for 4 further cycles.
4. From Q=0000, op=101, sdata=1101, N=4 -> Q sequence 1000,0100,1010,1101; result=1101.
5. From Q=1000, op=100 (asr), N=2 -> 1100,1110; new command held valid during busy is not accepted until the done cycle, then runs correctly back-to-back.
6. N=0 with op=000 on Q=0110 -> done next cycle, result=0110, Q unchanged. Separately, op=011 (lsl) N=5 with rst_n pulsed low after 2 updates -> Q frozen at partial value, no done, sel=001.
